// File: rtl/uart_tx_mmio.sv
// Bus-mapped 8N1 UART transmitter: byte writes fill a circular TX FIFO, the FSM serializes frames on txd.
// Register window: 0x0 TXDATA (W), 0x4 STATUS (R, W1 to bit3 clears overflow), 0x8 CTRL enable (R/W).
module uart_tx_mmio #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memWrite,
   input  logic        memRead,
   input  logic [3:0]  addr,
   input  logic [31:0] wrData,
   output logic [31:0] rdData,
   output logic        txd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            txd_q, txd_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            en_q, en_d;
   logic [31:0]     rd_data_q, rd_data_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            fifo_full, fifo_empty;
   logic            push_req, push_ok, pop;
   logic [31:0]     status;
   logic            unused_wr_hi;

   assign unused_wr_hi = ^wrData[31:8];

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push_req   = memWrite && (addr == 4'h0);
   // Full is judged on the registered count, so a same-cycle pop never rescues a push.
   assign push_ok    = push_req && !fifo_full;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_q && !fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = BAUD_RELOAD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_q == '0) begin
               baud_d  = BAUD_RELOAD;
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         ST_DATA: begin
            if (baud_q == '0) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         ST_STOP: begin
            if (baud_q == '0) begin
               // Chain straight into the next start bit so queued frames are contiguous.
               if (en_q && !fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  baud_d  = BAUD_RELOAD;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push_ok) - CW'(pop);

      ovf_d = ovf_q;
      if (push_req && fifo_full) begin
         ovf_d = 1'b1;
      end else if (memWrite && (addr == 4'h4) && wrData[3]) begin
         ovf_d = 1'b0;
      end

      en_d = en_q;
      if (memWrite && (addr == 4'h8)) begin
         en_d = wrData[0];
      end

      status = {16'h0, 8'(count_q), 4'h0, ovf_q, fifo_empty, fifo_full, state_q != ST_IDLE};

      rd_data_d = rd_data_q;
      if (memRead) begin
         case (addr)
            4'h4:    rd_data_d = status;
            4'h8:    rd_data_d = {31'h0, en_q};
            default: rd_data_d = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         txd_q     <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         en_q      <= 1'b1;
         rd_data_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         en_q      <= en_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wrData[7:0];
      end
   end

   assign rdData = rd_data_q;
   assign txd    = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_mmio;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        memWrite = 1'b0;
   logic        memRead = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [31:0] wrData = 32'h0;
   logic [31:0] rdData;
   logic        txd;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_mmio #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .memWrite (memWrite),
      .memRead  (memRead),
      .addr     (addr),
      .wrData   (wrData),
      .rdData   (rdData),
      .txd      (txd)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      memWrite = 1'b1;
      addr     = a;
      wrData   = d;
      tick();
      memWrite = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      memRead = 1'b1;
      addr    = a;
      tick();
      memRead = 1'b0;
      d       = rdData;
   endtask

   // 40 samples, one per cycle, starting at the current cycle; bit i = txd at cycle i.
   task automatic capture_frame(output logic [39:0] w);
      for (int i = 0; i < 40; i++) begin
         w[i] = txd;
         tick();
      end
   endtask

   task automatic count_low(input int n, output int lows);
      lows = 0;
      for (int i = 0; i < n; i++) begin
         if (txd !== 1'b1) lows++;
         tick();
      end
   endtask

   function automatic logic [39:0] frame_wave(input logic [7:0] b);
      logic [39:0] w;
      logic        v;
      for (int i = 0; i < 10; i++) begin
         v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
         w[i*4 +: 4] = {4{v}};
      end
      return w;
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", txd); end
      checks++;
      if (rdData !== 32'h0) begin failures++; $display("FAIL reset_rddata: got %h expected 00000000", rdData); end
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_0004) begin failures++; $display("FAIL reset_status: got %h expected 00000004", d); end
      bus_read(4'h8, d);
      checks++;
      if (d !== 32'h0000_0001) begin failures++; $display("FAIL reset_ctrl: got %h expected 00000001", d); end
   endtask

   task automatic test_single_byte();
      logic [39:0] w;
      logic [31:0] d;
      bus_write(4'h0, 32'h55);
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL single_early_fall: got %b expected 1", txd); end
      tick();
      capture_frame(w);
      checks++;
      if (w !== 40'hF0F0F0F0F0) begin failures++; $display("FAIL single_frame: got %h expected f0f0f0f0f0", w); end
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_0004) begin failures++; $display("FAIL single_status: got %h expected 00000004", d); end
   endtask

   task automatic test_back_to_back();
      logic [39:0] w1, w2;
      logic [31:0] d;
      bus_write(4'h0, 32'h41);
      bus_write(4'h0, 32'h42);
      capture_frame(w1);
      capture_frame(w2);
      checks++;
      if (w1 !== 40'hF0F00000F0) begin failures++; $display("FAIL b2b_frame1: got %h expected f0f00000f0", w1); end
      checks++;
      if (w2 !== 40'hF0F0000F00) begin failures++; $display("FAIL b2b_frame2: got %h expected f0f0000f00", w2); end
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_0004) begin failures++; $display("FAIL b2b_status: got %h expected 00000004", d); end
   endtask

   task automatic test_overflow();
      logic [39:0] w;
      logic [31:0] d;
      logic [7:0]  b;
      int          lows;
      bus_write(4'h8, 32'h0);
      for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h11 + 32'(i));
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_040A) begin failures++; $display("FAIL ovf_status_full: got %h expected 0000040a", d); end
      bus_write(4'h4, 32'h8);
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_0402) begin failures++; $display("FAIL ovf_status_clear: got %h expected 00000402", d); end
      bus_write(4'h8, 32'h1);
      tick();
      for (int f = 0; f < 4; f++) begin
         b = 8'h11 + 8'(f);
         capture_frame(w);
         checks++;
         if (w !== frame_wave(b)) begin
            failures++;
            $display("FAIL ovf_frame%0d: got %h expected %h", f, w, frame_wave(b));
         end
      end
      count_low(45, lows);
      checks++;
      if (lows !== 0) begin failures++; $display("FAIL ovf_fifth_absent: got %0d low cycles expected 0", lows); end
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_0004) begin failures++; $display("FAIL ovf_status_end: got %h expected 00000004", d); end
   endtask

   task automatic test_disable_mid_frame();
      logic [39:0] w;
      logic [31:0] d;
      int          lows;
      bus_write(4'h0, 32'h21);
      bus_write(4'h0, 32'h22);
      for (int i = 0; i < 40; i++) begin
         w[i]     = txd;
         memWrite = (i == 12);
         addr     = 4'h8;
         wrData   = 32'h0;
         tick();
      end
      memWrite = 1'b0;
      checks++;
      if (w !== frame_wave(8'h21)) begin failures++; $display("FAIL dis_frame1: got %h expected %h", w, frame_wave(8'h21)); end
      count_low(12, lows);
      checks++;
      if (lows !== 0) begin failures++; $display("FAIL dis_idle: got %0d low cycles expected 0", lows); end
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_0100) begin failures++; $display("FAIL dis_status: got %h expected 00000100", d); end
      bus_read(4'h8, d);
      checks++;
      if (d !== 32'h0000_0000) begin failures++; $display("FAIL dis_ctrl: got %h expected 00000000", d); end
      bus_write(4'h8, 32'h1);
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL dis_reenable_early: got %b expected 1", txd); end
      tick();
      capture_frame(w);
      checks++;
      if (w !== frame_wave(8'h22)) begin failures++; $display("FAIL dis_frame2: got %h expected %h", w, frame_wave(8'h22)); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      int          lows;
      for (int i = 0; i < 4; i++) bus_write(4'h0, 32'h31 + 32'(i));
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL rstmid_txd: got %b expected 1", txd); end
      count_low(50, lows);
      checks++;
      if (lows !== 0) begin failures++; $display("FAIL rstmid_no_frames: got %0d low cycles expected 0", lows); end
      bus_read(4'h4, d);
      checks++;
      if (d !== 32'h0000_0004) begin failures++; $display("FAIL rstmid_status: got %h expected 00000004", d); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_disable_mid_frame();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
